// File: rtl/eth_pkg.sv
// Shared Ethernet framing definitions: transmit FSM states, framing bytes and
// the byte-wide reflected CRC-32 step used by the transmit framer and receive checker.
package eth_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_ABORT,
        ST_DISCARD,
        ST_IFG
    } tx_state_e;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC32_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;

    function automatic logic [31:0] crc32_next(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h00_0000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Running reflected CRC-32, one byte per enabled cycle; init reloads the seed.
module crc32_d8
    import eth_pkg::*;
(
    input  logic        aclk,
    input  logic        reset,
    input  logic        init_i,
    input  logic        en_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    logic [31:0] crc_q;

    always_ff @(posedge aclk) begin
        if (reset || init_i) begin
            crc_q <= CRC32_INIT;
        end else if (en_i) begin
            crc_q <= crc32_next(crc_q, data_i);
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD, zero padding, CRC-32 FCS, underrun abort
// and inter-frame gap, fed from a byte-wide valid/ready stream.
//
// state   | meaning
// IDLE    | waiting for s_tvalid; CRC held at seed
// PRE     | emitting preamble bytes
// SFD     | last preamble byte on the wire, SFD registered on exit
// DATA    | accepting payload (s_tready=1)
// PAD     | emitting zero pad up to MIN_FRAME
// FCS     | emitting ~crc LSB first, then dropping tx_en
// ABORT   | single tx_er cycle after an underrun
// DISCARD | draining the rest of the aborted frame
// IFG     | tx_en low for IFG_CYCLES cycles
module gmii_tx_framer
    import eth_pkg::*;
#(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_FRAME    = 60,
    parameter int IFG_CYCLES   = 12
) (
    input  logic        aclk,
    input  logic        reset,
    input  logic [7:0]  s_tdata,
    input  logic        s_tvalid,
    input  logic        s_tlast,
    output logic        s_tready,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en,
    output logic        gmii_tx_er,
    output logic        tx_busy,
    output logic [31:0] frames_sent,
    output logic [15:0] underruns
);

    localparam logic [7:0]  PRE_LOAD = (PREAMBLE_LEN > 1) ? 8'(PREAMBLE_LEN - 2) : 8'd0;
    localparam logic [7:0]  IFG_LOAD = 8'(IFG_CYCLES - 1);
    localparam logic [10:0] MIN_CNT  = 11'(MIN_FRAME);

    tx_state_e   state_q;
    logic [7:0]  txd_q;
    logic        tx_en_q;
    logic        tx_er_q;
    logic [7:0]  cnt_q;
    logic [10:0] byte_cnt_q;
    logic [10:0] byte_cnt_d;
    logic        tlast_seen_q;
    logic [31:0] frames_q;
    logic [15:0] underruns_q;

    logic        crc_init;
    logic        crc_en;
    logic [7:0]  crc_data;
    logic [31:0] crc_val;
    logic [31:0] fcs_word;
    logic [7:0]  fcs_byte;

    crc32_d8 u_crc (
        .aclk   (aclk),
        .reset  (reset),
        .init_i (crc_init),
        .en_i   (crc_en),
        .data_i (crc_data),
        .crc_o  (crc_val)
    );

    assign s_tready   = (state_q == ST_DATA) || (state_q == ST_DISCARD);
    assign byte_cnt_d = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_q + 11'd1;
    assign fcs_word   = ~crc_val;

    always_comb begin
        crc_init = (state_q == ST_IDLE);
        crc_en   = 1'b0;
        crc_data = s_tdata;
        if (state_q == ST_DATA && s_tvalid) begin
            crc_en = 1'b1;
        end else if (state_q == ST_PAD) begin
            crc_en   = 1'b1;
            crc_data = 8'h00;
        end
    end

    // cnt_q counts 4..1 while FCS bytes go out; 0 is the tx_en drop cycle
    always_comb begin
        case (cnt_q[2:0])
            3'd4:    fcs_byte = fcs_word[7:0];
            3'd3:    fcs_byte = fcs_word[15:8];
            3'd2:    fcs_byte = fcs_word[23:16];
            default: fcs_byte = fcs_word[31:24];
        endcase
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            txd_q        <= 8'h00;
            tx_en_q      <= 1'b0;
            tx_er_q      <= 1'b0;
            cnt_q        <= 8'd0;
            byte_cnt_q   <= 11'd0;
            tlast_seen_q <= 1'b0;
            frames_q     <= 32'd0;
            underruns_q  <= 16'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    txd_q   <= 8'h00;
                    tx_en_q <= 1'b0;
                    tx_er_q <= 1'b0;
                    if (s_tvalid) begin
                        txd_q        <= PREAMBLE_BYTE;
                        tx_en_q      <= 1'b1;
                        byte_cnt_q   <= 11'd0;
                        tlast_seen_q <= 1'b0;
                        cnt_q        <= PRE_LOAD;
                        state_q      <= (PREAMBLE_LEN == 1) ? ST_SFD : ST_PRE;
                    end
                end
                ST_PRE: begin
                    txd_q <= PREAMBLE_BYTE;
                    if (cnt_q == 8'd0) state_q <= ST_SFD;
                    else               cnt_q   <= cnt_q - 8'd1;
                end
                ST_SFD: begin
                    txd_q   <= SFD_BYTE;
                    state_q <= ST_DATA;
                end
                ST_DATA: begin
                    if (s_tvalid) begin
                        txd_q      <= s_tdata;
                        byte_cnt_q <= byte_cnt_d;
                        if (s_tlast) begin
                            tlast_seen_q <= 1'b1;
                            cnt_q        <= 8'd4;
                            state_q      <= (byte_cnt_d < MIN_CNT) ? ST_PAD : ST_FCS;
                        end
                    end else begin
                        txd_q   <= 8'h00;
                        tx_er_q <= 1'b1;
                        state_q <= ST_ABORT;
                        if (underruns_q != 16'hFFFF) underruns_q <= underruns_q + 16'd1;
                    end
                end
                ST_PAD: begin
                    txd_q      <= 8'h00;
                    byte_cnt_q <= byte_cnt_d;
                    if (byte_cnt_d == MIN_CNT) state_q <= ST_FCS;
                end
                ST_FCS: begin
                    if (cnt_q == 8'd0) begin
                        txd_q    <= 8'h00;
                        tx_en_q  <= 1'b0;
                        frames_q <= frames_q + 32'd1;
                        cnt_q    <= IFG_LOAD;
                        state_q  <= ST_IFG;
                    end else begin
                        txd_q <= fcs_byte;
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                ST_ABORT: begin
                    txd_q   <= 8'h00;
                    tx_en_q <= 1'b0;
                    tx_er_q <= 1'b0;
                    cnt_q   <= IFG_LOAD;
                    state_q <= tlast_seen_q ? ST_IFG : ST_DISCARD;
                end
                ST_DISCARD: begin
                    if (s_tvalid && s_tlast) begin
                        cnt_q   <= IFG_LOAD;
                        state_q <= ST_IFG;
                    end
                end
                ST_IFG: begin
                    if (cnt_q == 8'd0) state_q <= ST_IDLE;
                    else               cnt_q   <= cnt_q - 8'd1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign gmii_txd    = txd_q;
    assign gmii_tx_en  = tx_en_q;
    assign gmii_tx_er  = tx_er_q;
    assign tx_busy     = (state_q != ST_IDLE);
    assign frames_sent = frames_q;
    assign underruns   = underruns_q;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Bench for gmii_tx_framer: random payloads compared against a frame-level model
// (preamble, pad, bit-serial CRC-32), plus gap, abort and reset scenarios.
module tb_gmii_tx_framer;

    typedef logic [7:0] bq_t[$];

    logic        aclk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  s_tdata = 8'h00;
    logic        s_tvalid = 1'b0;
    logic        s_tvalid0 = 1'b0;
    logic        s_tlast = 1'b0;

    logic        s_tready, s_tready0;
    logic [7:0]  gmii_txd, gmii_txd0;
    logic        gmii_tx_en, gmii_tx_en0;
    logic        gmii_tx_er, gmii_tx_er0;
    logic        tx_busy, tx_busy0;
    logic [31:0] frames_sent, frames_sent0;
    logic [15:0] underruns, underruns0;

    gmii_tx_framer dut (
        .aclk(aclk), .reset(reset), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .s_tready(s_tready), .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en), .gmii_tx_er(gmii_tx_er),
        .tx_busy(tx_busy), .frames_sent(frames_sent), .underruns(underruns)
    );

    gmii_tx_framer #(.MIN_FRAME(0)) dut0 (
        .aclk(aclk), .reset(reset), .s_tdata(s_tdata), .s_tvalid(s_tvalid0), .s_tlast(s_tlast),
        .s_tready(s_tready0), .gmii_txd(gmii_txd0), .gmii_tx_en(gmii_tx_en0), .gmii_tx_er(gmii_tx_er0),
        .tx_busy(tx_busy0), .frames_sent(frames_sent0), .underruns(underruns0)
    );

    always #4 aclk = ~aclk;

    int  checks = 0;
    int  errors = 0;
    bq_t pl_q, exp_q, cap_q, cap0_q;
    int  gap_q[$];
    int  en_cycles, en0_cycles, er_cycles, rdy_low, low_run;
    bit  seen_high;

    initial begin
        forever begin
            @(negedge aclk);
            if (gmii_tx_er || gmii_tx_er0) er_cycles++;
            if (gmii_tx_en) begin
                cap_q.push_back(gmii_txd);
                en_cycles++;
                if (seen_high && low_run > 0) gap_q.push_back(low_run);
                seen_high = 1'b1;
                low_run = 0;
            end else begin
                low_run++;
                if (s_tready) rdy_low++;
            end
            if (gmii_tx_en0) begin
                cap0_q.push_back(gmii_txd0);
                en0_cycles++;
            end
        end
    end

    task automatic clear_mon();
        cap_q.delete(); cap0_q.delete(); gap_q.delete(); exp_q.delete();
        en_cycles = 0; en0_cycles = 0; er_cycles = 0; rdy_low = 0; low_run = 0; seen_high = 1'b0;
    endtask

    function automatic logic [31:0] ref_fcs(input bq_t d);
        logic [31:0] c;
        logic fb;
        c = 32'hFFFF_FFFF;
        foreach (d[k]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ d[k][b];
                c = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return ~c;
    endfunction

    function automatic void add_frame(input bq_t body_in, input int min_len);
        bq_t body;
        logic [31:0] f;
        body = body_in;
        for (int k = 0; k < 7; k++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        while (body.size() < min_len) body.push_back(8'h00);
        foreach (body[k]) exp_q.push_back(body[k]);
        f = ref_fcs(body);
        for (int k = 0; k < 4; k++) exp_q.push_back(f[8*k +: 8]);
    endfunction

    function automatic int first_diff(input bq_t e, input bq_t a);
        int n;
        n = (e.size() < a.size()) ? e.size() : a.size();
        for (int k = 0; k < n; k++) if (e[k] !== a[k]) return k;
        if (e.size() != a.size()) return n;
        return -1;
    endfunction

    function automatic logic [7:0] at(input bq_t q, input int k);
        if (k >= 0 && k < q.size()) return q[k];
        return 8'hxx;
    endfunction

    function automatic bq_t rand_payload(input int n);
        bq_t q;
        for (int k = 0; k < n; k++) q.push_back(8'($urandom_range(0, 255)));
        return q;
    endfunction

    // Drives pl_q; a stall drops s_tvalid before byte stall_at, rst_at raises reset before that byte.
    task automatic drive_frame(input bit sel, input int len, input int stall_at, input int stall_len,
                               input int rst_at, output int first_acc, output bit ok);
        int i, cyc;
        bit acc, stalled;
        i = 0; cyc = 0; stalled = 1'b0; first_acc = -1; ok = 1'b1;
        while (i < len && ok) begin
            if (i == rst_at) begin
                reset = 1'b1;
                break;
            end
            if (i == stall_at && !stalled) begin
                stalled = 1'b1;
                s_tvalid = 1'b0; s_tvalid0 = 1'b0;
                repeat (stall_len) @(posedge aclk);
                #1;
            end
            s_tdata = pl_q[i];
            s_tlast = (i == len - 1);
            if (sel) s_tvalid0 = 1'b1; else s_tvalid = 1'b1;
            @(negedge aclk);
            acc = sel ? s_tready0 : s_tready;
            @(posedge aclk); #1;
            if (acc) begin
                if (first_acc < 0) first_acc = cyc;
                i++;
            end
            cyc++;
            if (cyc > 20000) ok = 1'b0;
        end
        s_tvalid = 1'b0; s_tvalid0 = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((tx_busy || tx_busy0) && n < 5000) begin
            @(posedge aclk); #1;
            n++;
        end
        checks++;
        if (tx_busy || tx_busy0) begin
            errors++;
            $display("FAIL %s_idle: still busy after %0d cycles, want idle", name, n);
        end
        repeat (2) @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        reset = 1'b0;
        @(negedge aclk);
        checks++;
        if ({gmii_txd, gmii_tx_en, gmii_tx_er, s_tready, tx_busy} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got txd=%h en=%b er=%b rdy=%b busy=%b want all 0",
                     gmii_txd, gmii_tx_en, gmii_tx_er, s_tready, tx_busy);
        end
        checks++;
        if (frames_sent !== 32'd0 || underruns !== 16'd0 || frames_sent0 !== 32'd0 || underruns0 !== 16'd0) begin
            errors++;
            $display("FAIL reset_counters: got frames=%0d underruns=%0d want 0 0", frames_sent, underruns);
        end
        checks++;
        if (gmii_tx_en0 !== 1'b0 || tx_busy0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_dut0: got en=%b busy=%b want 0 0", gmii_tx_en0, tx_busy0);
        end
        @(posedge aclk); #1;
    endtask

    task automatic test_check_value();
        int fa, d;
        bit ok;
        clear_mon();
        pl_q.delete();
        for (int k = 0; k < 9; k++) pl_q.push_back(8'(8'h31 + k));
        for (int k = 0; k < 7; k++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        foreach (pl_q[k]) exp_q.push_back(pl_q[k]);
        exp_q.push_back(8'h26); exp_q.push_back(8'h39); exp_q.push_back(8'hF4); exp_q.push_back(8'hCB);
        drive_frame(1'b1, 9, -1, 0, -1, fa, ok);
        wait_idle("check_value");
        d = first_diff(exp_q, cap0_q);
        checks++;
        if (d !== -1) begin
            errors++;
            $display("FAIL check_value_seq: byte %0d got %h want %h (%0d bytes, want %0d)",
                     d, at(cap0_q, d), at(exp_q, d), cap0_q.size(), exp_q.size());
        end
        checks++;
        if (en0_cycles !== 21) begin
            errors++;
            $display("FAIL check_value_en_len: got %0d want 21", en0_cycles);
        end
        checks++;
        if (frames_sent0 !== 32'd1) begin
            errors++;
            $display("FAIL check_value_frames: got %0d want 1", frames_sent0);
        end
        checks++;
        if (fa !== 8 || !ok) begin
            errors++;
            $display("FAIL check_value_ready_lat: got %0d want 8", fa);
        end
    endtask

    task automatic test_pad();
        int fa, d;
        bit ok;
        logic [31:0] f0;
        clear_mon();
        f0 = frames_sent;
        pl_q = rand_payload(10);
        add_frame(pl_q, 60);
        drive_frame(1'b0, 10, -1, 0, -1, fa, ok);
        wait_idle("pad");
        d = first_diff(exp_q, cap_q);
        checks++;
        if (d !== -1) begin
            errors++;
            $display("FAIL pad_seq: byte %0d got %h want %h (%0d bytes, want %0d)",
                     d, at(cap_q, d), at(exp_q, d), cap_q.size(), exp_q.size());
        end
        checks++;
        if (en_cycles !== 72) begin
            errors++;
            $display("FAIL pad_en_len: got %0d want 72", en_cycles);
        end
        checks++;
        if (fa !== 8 || !ok) begin
            errors++;
            $display("FAIL pad_ready_lat: got %0d want 8", fa);
        end
        checks++;
        if (frames_sent !== f0 + 32'd1 || er_cycles !== 0) begin
            errors++;
            $display("FAIL pad_frames: got frames=%0d er=%0d want %0d 0", frames_sent, er_cycles, f0 + 32'd1);
        end
    endtask

    task automatic test_back_to_back();
        int fa, d, g;
        bit ok1, ok2;
        bq_t f2;
        logic [31:0] f0;
        clear_mon();
        f0 = frames_sent;
        pl_q = rand_payload(64);
        f2 = rand_payload(64);
        add_frame(pl_q, 60);
        add_frame(f2, 60);
        drive_frame(1'b0, 64, -1, 0, -1, fa, ok1);
        pl_q = f2;
        drive_frame(1'b0, 64, -1, 0, -1, fa, ok2);
        wait_idle("b2b");
        d = first_diff(exp_q, cap_q);
        checks++;
        if (d !== -1 || !ok1 || !ok2) begin
            errors++;
            $display("FAIL b2b_seq: byte %0d got %h want %h (%0d bytes, want %0d)",
                     d, at(cap_q, d), at(exp_q, d), cap_q.size(), exp_q.size());
        end
        g = (gap_q.size() == 1) ? gap_q[0] : -gap_q.size();
        checks++;
        if (g !== 13) begin
            errors++;
            $display("FAIL b2b_gap: got %0d (negative = gap count) want 13", g);
        end
        checks++;
        if (rdy_low !== 0) begin
            errors++;
            $display("FAIL b2b_ready_in_gap: got %0d ready cycles while tx_en low, want 0", rdy_low);
        end
        checks++;
        if (frames_sent !== f0 + 32'd2) begin
            errors++;
            $display("FAIL b2b_frames: got %0d want %0d", frames_sent, f0 + 32'd2);
        end
    endtask

    task automatic test_underrun();
        int fa, d;
        bit ok1, ok2;
        bq_t fb;
        logic [31:0] f0;
        clear_mon();
        f0 = frames_sent;
        pl_q = rand_payload(100);
        fb = rand_payload(64);
        for (int k = 0; k < 7; k++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int k = 0; k < 20; k++) exp_q.push_back(pl_q[k]);
        exp_q.push_back(8'h00);
        add_frame(fb, 60);
        drive_frame(1'b0, 100, 20, 3, -1, fa, ok1);
        pl_q = fb;
        drive_frame(1'b0, 64, -1, 0, -1, fa, ok2);
        wait_idle("underrun");
        d = first_diff(exp_q, cap_q);
        checks++;
        if (d !== -1 || !ok1 || !ok2) begin
            errors++;
            $display("FAIL underrun_seq: byte %0d got %h want %h (%0d bytes, want %0d)",
                     d, at(cap_q, d), at(exp_q, d), cap_q.size(), exp_q.size());
        end
        checks++;
        if (er_cycles !== 1) begin
            errors++;
            $display("FAIL underrun_er_cycles: got %0d want 1", er_cycles);
        end
        checks++;
        if (underruns !== 16'd1) begin
            errors++;
            $display("FAIL underrun_count: got %0d want 1", underruns);
        end
        checks++;
        if (frames_sent !== f0 + 32'd1) begin
            errors++;
            $display("FAIL underrun_frames: got %0d want %0d", frames_sent, f0 + 32'd1);
        end
    endtask

    task automatic test_reset_mid();
        int fa, d;
        bit ok;
        clear_mon();
        pl_q = rand_payload(100);
        drive_frame(1'b0, 100, -1, 0, 30, fa, ok);
        @(posedge aclk); #1;
        checks++;
        if (gmii_tx_en !== 1'b0 || s_tready !== 1'b0 || tx_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got en=%b rdy=%b busy=%b want 0 0 0", gmii_tx_en, s_tready, tx_busy);
        end
        checks++;
        if (frames_sent !== 32'd0 || underruns !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid_counters: got frames=%0d underruns=%0d want 0 0", frames_sent, underruns);
        end
        reset = 1'b0;
        @(posedge aclk); #1;
        clear_mon();
        pl_q = rand_payload(64);
        add_frame(pl_q, 60);
        drive_frame(1'b0, 64, -1, 0, -1, fa, ok);
        wait_idle("reset_mid");
        d = first_diff(exp_q, cap_q);
        checks++;
        if (d !== -1 || !ok) begin
            errors++;
            $display("FAIL reset_mid_seq: byte %0d got %h want %h (%0d bytes, want %0d)",
                     d, at(cap_q, d), at(exp_q, d), cap_q.size(), exp_q.size());
        end
        checks++;
        if (frames_sent !== 32'd1) begin
            errors++;
            $display("FAIL reset_mid_frames: got %0d want 1", frames_sent);
        end
    endtask

    task automatic test_long_frame();
        int fa, d;
        bit ok;
        logic [31:0] f0;
        clear_mon();
        f0 = frames_sent;
        pl_q = rand_payload(2100);
        add_frame(pl_q, 60);
        drive_frame(1'b0, 2100, -1, 0, -1, fa, ok);
        wait_idle("long");
        d = first_diff(exp_q, cap_q);
        checks++;
        if (d !== -1 || !ok) begin
            errors++;
            $display("FAIL long_seq: byte %0d got %h want %h (%0d bytes, want %0d)",
                     d, at(cap_q, d), at(exp_q, d), cap_q.size(), exp_q.size());
        end
        checks++;
        if (frames_sent !== f0 + 32'd1) begin
            errors++;
            $display("FAIL long_frames: got %0d want %0d", frames_sent, f0 + 32'd1);
        end
    endtask

    task automatic test_random_frames();
        int fa, d, len;
        bit ok, all_ok;
        logic [31:0] f0;
        clear_mon();
        f0 = frames_sent;
        all_ok = 1'b1;
        for (int n = 0; n < 6; n++) begin
            len = $urandom_range(1, 130);
            pl_q = rand_payload(len);
            add_frame(pl_q, 60);
            drive_frame(1'b0, len, -1, 0, -1, fa, ok);
            all_ok &= ok;
            repeat ($urandom_range(0, 20)) @(posedge aclk);
            #1;
        end
        wait_idle("random");
        d = first_diff(exp_q, cap_q);
        checks++;
        if (d !== -1 || !all_ok) begin
            errors++;
            $display("FAIL random_seq: byte %0d got %h want %h (%0d bytes, want %0d)",
                     d, at(cap_q, d), at(exp_q, d), cap_q.size(), exp_q.size());
        end
        checks++;
        if (frames_sent !== f0 + 32'd6 || er_cycles !== 0) begin
            errors++;
            $display("FAIL random_frames: got frames=%0d er=%0d want %0d 0", frames_sent, er_cycles, f0 + 32'd6);
        end
    endtask

    initial begin
        test_reset();
        test_check_value();
        test_pad();
        test_back_to_back();
        test_underrun();
        test_reset_mid();
        test_long_frame();
        test_random_frames();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
